// File: rtl/seq_detect_ctrl.sv
// Byte-serialising 4-bit pattern detector: accepts a byte, shifts it MSB first
// through a Mealy matcher, then holds per-byte and running match counts.
module seq_detect_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cfg_pattern,
  input  logic        cfg_load,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        z,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  match_cnt,
  output logic [15:0] total_cnt,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_pattern;
  logic [2:0]  r_hist;
  logic [1:0]  r_fill;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_byte;
  logic [3:0]  r_match_cnt;
  logic [15:0] r_total_cnt;

  logic w_bit;
  logic w_match;
  logic w_accept;

  assign w_bit    = r_byte[r_bit_idx];
  // The match looks at the three stored bits plus the bit on the wire this cycle.
  assign w_match  = (r_state == S_SHIFT) && (r_fill == 2'd3) &&
                    ({r_hist, w_bit} == r_pattern);
  assign in_ready = (r_state == S_IDLE) && !cfg_load;
  assign w_accept = in_valid && in_ready;

  assign z         = w_match;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_SHIFT) || (r_state == S_DONE);
  assign match_cnt = r_match_cnt;
  assign total_cnt = r_total_cnt;

  // NOTE: all state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order in this block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pattern   <= 4'b1011;
      r_hist      <= 3'd0;
      r_fill      <= 2'd0;
      r_bit_idx   <= 3'd7;
      r_byte      <= 8'd0;
      r_match_cnt <= 4'd0;
      r_total_cnt <= 16'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_load) begin
            r_pattern <= cfg_pattern;
            r_hist    <= 3'd0;
            r_fill    <= 2'd0;
          end else if (w_accept) begin
            r_byte      <= in_data;
            r_bit_idx   <= 3'd7;
            r_match_cnt <= 4'd0;
            r_state     <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // History and fill carry across bytes so a match may straddle them.
          r_hist <= {r_hist[1:0], w_bit};
          if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
          if (w_match) begin
            r_match_cnt <= r_match_cnt + 4'd1;
            if (r_total_cnt != 16'hFFFF) r_total_cnt <= r_total_cnt + 16'd1;
          end
          if (r_bit_idx == 3'd0) r_state   <= S_DONE;
          else                   r_bit_idx <= r_bit_idx - 3'd1;
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/seq_detect_ctrl.md
SEQ_DETECT_CTRL -- requirements
Module: seq_detect_ctrl

Interface
REQ-001 clk  input  1  sole clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 cfg_pattern  input  4  detection pattern; bit 3 is the first bit of the stream.
REQ-004 cfg_load  input  1  when high in IDLE, loads cfg_pattern and clears detector history.
REQ-005 in_valid  input  1  parallel byte offered.
REQ-006 in_data  input  8  byte to be serialised MSB first.
REQ-007 in_ready  output  1  high only in IDLE with cfg_load low; the byte is accepted when in_valid and in_ready are both high.
REQ-008 z  output  1  Mealy match pulse, combinational, during SHIFT only.
REQ-009 out_valid  output  1  per-byte result available.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 match_cnt  output  4  matches within the last byte, 0..8.
REQ-012 total_cnt  output  16  running match total, saturating.
REQ-013 busy  output  1  high in SHIFT and DONE.

Function
REQ-014 FSM states: IDLE, SHIFT, DONE; unused encodings SHALL go to IDLE.
REQ-015 IDLE: cfg_load high -> pattern reg := cfg_pattern, hist := 0, fill := 0; stay in IDLE; no byte is accepted that cycle.
REQ-016 IDLE: in_valid and in_ready high -> capture in_data, bit_idx := 7, match_cnt := 0, next state SHIFT.
REQ-017 SHIFT: current bit b = byte[bit_idx]; each cycle: hist := {hist[1:0], b}, fill := min(fill+1, 3).
REQ-018 Match condition: fill == 3 and {hist, b} == pattern; z is high in that same cycle.
REQ-019 On a match: match_cnt +1; total_cnt +1 unless it equals 16'hFFFF, which holds.
REQ-020 Overlap is allowed: after a match, hist is not cleared; the next match may reuse the trailing 3 bits.
REQ-021 Detector history and fill persist across bytes, so a pattern may span a byte boundary; only cfg_load or rst clears them.
REQ-022 SHIFT lasts exactly 8 cycles (bit_idx 7 down to 0); after bit 0 -> DONE.
REQ-023 Latency: accept in cycle T; bits in T+1..T+8; out_valid high from T+9.
REQ-024 DONE: out_valid = 1; match_cnt stable; out_ready high -> IDLE next cycle; out_valid held indefinitely otherwise.
REQ-025 cfg_load outside IDLE is ignored; in_valid outside IDLE is not accepted.
REQ-026 z = 0 in IDLE and DONE; match_cnt holds its value in IDLE until the next acceptance.
REQ-027 Any pattern value, including 4'b0000 and 4'b1111, is legal.

Reset
REQ-028 rst high: state := IDLE, pattern := 4'b1011, hist := 0, fill := 0, bit_idx := 7, match_cnt := 0, total_cnt := 0.
REQ-029 After reset: z = 0, out_valid = 0, busy = 0, in_ready = 1.
REQ-030 rst asserted mid-SHIFT or in DONE SHALL abort immediately; the partial byte is discarded and no out_valid is produced.

Verification
REQ-031 Reset, then send 8'hBB (stream 10111011), pattern 1011 -> z pulses on the 4th and 8th SHIFT cycles; match_cnt = 2; total_cnt = 2; out_valid at T+9.
REQ-032 After cfg_load with 1011, send 8'hB6 (stream 10110110) -> overlapping matches on the 4th and 7th bits; match_cnt = 2.
REQ-033 After cfg_load with 1011, send 8'h05, then 8'h80 -> first byte match_cnt = 0; second byte match_cnt = 1, with z on its first SHIFT cycle (cross-byte match).
REQ-034 Pattern 1111, send 8'hFF -> match_cnt = 5 (bits 4..8); cfg_load pulsed during SHIFT is ignored.
REQ-035 Hold out_ready low for 5 cycles in DONE -> out_valid and match_cnt stable, in_ready = 0; the byte offered in this period is accepted only after return to IDLE.
REQ-036 Assert rst on the 3rd SHIFT cycle -> all outputs at reset values next cycle; total_cnt = 0; no out_valid.
